// File: rtl/sync_gen_pkg.sv
// -----------------------------------------------------------------------------
// sync_gen_pkg
//
// Purpose:
//   Shared definitions for the sync pulse generator slice. Holds the FSM state
//   encoding, the bit positions of the software control word, and the default
//   widths used by the generator.
//
// Contents:
//   state_t              IDLE / ARMED / RUN state encoding
//   PERIODIC_BIT         ctrl_word bit selecting periodic (1) or one-shot (0)
//   ARM_BIT              ctrl_word bit whose rising edge starts an operation
//   STOP_BIT             ctrl_word level bit that forces the block to IDLE
//   DEFAULT_PERIOD_W     default width of the period field (P = period - 1)
//   DEFAULT_CNT_W        default width of the emitted-pulse counter
//   CTRL_W               width of the software control word
// -----------------------------------------------------------------------------
package sync_gen_pkg;

  localparam int CTRL_W           = 32;

  localparam int PERIODIC_BIT     = 31;
  localparam int ARM_BIT          = 30;
  localparam int STOP_BIT         = 29;

  localparam int DEFAULT_PERIOD_W = 24;
  localparam int DEFAULT_CNT_W    = 32;

  // ARMED is only reachable when the block aligns to the external reference.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage : sync_gen_pkg

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
//
// Purpose:
//   Registers (or synchronises) a W-bit input and detects a rising edge on one
//   selected bit of the registered value.
//
//   STAGES = 0 : the input is already in the clock domain; it is captured by a
//                single plain register.
//   STAGES > 0 : the input is asynchronous; it passes through a chain of
//                STAGES synchroniser flops.
//
//   A separate history flop holds the previous value of the selected bit, and
//   rise = level & ~history. Rise detection is held off until the pipeline has
//   been refilled after reset, so a bit that is already high when reset is
//   released is treated as a level, not as an edge.
//
// Parameters:
//   STAGES    number of synchroniser flops (0 = single capture register)
//   W         width of the registered vector
//   RISE_BIT  index of the bit whose rising edge is reported
//
// Ports:
//   clk       clock, all logic on the rising edge
//   rst_n     synchronous active-low reset
//   d         raw input vector
//   level     registered / synchronised vector
//   rise      one-cycle strobe on a 0->1 transition of level[RISE_BIT]
// -----------------------------------------------------------------------------
module sync_edge_det #(
  parameter int STAGES   = 2,
  parameter int W        = 1,
  parameter int RISE_BIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic         rise
);

  // A zero-stage build still needs one capture register.
  localparam int DEPTH = (STAGES == 0) ? 1 : STAGES;

  logic [W-1:0]   stage_q [DEPTH];
  logic           hist_q;
  logic [DEPTH:0] prime_q;

  // Capture / synchroniser chain; stage_q[0] is the first flop seeing d.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign level = stage_q[DEPTH-1];

  // History flop for the watched bit, plus a priming shift register that
  // becomes all ones once the chain and the history flop both hold post-reset
  // samples. Until then a high level cannot be mistaken for an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q  <= 1'b0;
      prime_q <= '0;
    end else begin
      hist_q  <= level[RISE_BIT];
      prime_q <= {prime_q[DEPTH-1:0], 1'b1};
    end
  end

  assign rise = prime_q[DEPTH] & level[RISE_BIT] & ~hist_q;

endmodule : sync_edge_det

// File: rtl/sync_pulse_gen.sv
// -----------------------------------------------------------------------------
// sync_pulse_gen
//
// Purpose:
//   Software-controlled sync pulse generator. A rising edge on the arm bit of
//   the control word starts an operation; the block then emits one-cycle
//   pulses on sync_out every P+1 cycles (periodic mode) or a single pulse
//   (one-shot mode). The stop bit forces the block back to IDLE.
//
//   Build option SYNC_PULSE_GEN_EXT_ALIGN_EN:
//     defined   - after arming, the block waits in ARMED for a synchronised
//                 rising edge of sync_in before the first pulse.
//     undefined - arming goes straight to RUN; sync_in is ignored and has no
//                 flops behind it.
//
// Parameters:
//   PERIOD_W    width of the period field ctrl_word[PERIOD_W-1:0] (P)
//   CNT_W       width of sync_count
//
// Ports:
//   user_clk    clock, all logic on the rising edge
//   user_rst_n  synchronous active-low reset
//   ctrl_word   [31] periodic, [30] arm (rising edge), [29] stop (level),
//               [PERIOD_W-1:0] period minus one
//   sync_in     asynchronous external sync reference
//   sync_out    registered one-cycle sync pulse
//   armed       high whenever the state is not IDLE
//   sync_count  pulses emitted since the last arm (wraps silently)
// -----------------------------------------------------------------------------
module sync_pulse_gen
  import sync_gen_pkg::*;
#(
  parameter int PERIOD_W = DEFAULT_PERIOD_W,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [CTRL_W-1:0] ctrl_word,
  input  logic              sync_in,
  output logic              sync_out,
  output logic              armed,
  output logic [CNT_W-1:0]  sync_count
);

  logic [CTRL_W-1:0]   ctrl_q;
  logic                arm_edge;
  logic                sync_rise;
  logic                periodic;
  logic                stop;
  logic [PERIOD_W-1:0] period_p;

  state_t              state_q;
  logic [PERIOD_W-1:0] timer_q;
  logic [PERIOD_W-1:0] p_lat_q;

  // The control word is already in the user_clk domain, so it is simply
  // registered once and the arm bit is edge-detected on the registered copy.
  sync_edge_det #(
    .STAGES   (0),
    .W        (CTRL_W),
    .RISE_BIT (ARM_BIT)
  ) u_ctrl_det (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .d     (ctrl_word),
    .level (ctrl_q),
    .rise  (arm_edge)
  );

  assign periodic = ctrl_q[PERIODIC_BIT];
  assign stop     = ctrl_q[STOP_BIT];
  assign period_p = ctrl_q[PERIOD_W-1:0];

  // The arm bit is consumed inside the edge detector and the bits between
  // the period field and the control bits carry no meaning here.
  generate
    if (PERIOD_W < STOP_BIT) begin : g_spare_bits
      logic unused_ctrl_bits;
      assign unused_ctrl_bits = ^{ctrl_q[ARM_BIT], ctrl_q[STOP_BIT-1:PERIOD_W]};
    end else begin : g_no_spare_bits
      logic unused_ctrl_bits;
      assign unused_ctrl_bits = ctrl_q[ARM_BIT];
    end
  endgenerate

`ifdef SYNC_PULSE_GEN_EXT_ALIGN_EN
  // sync_in is asynchronous: two synchroniser flops, then rise detection.
  localparam state_t START_STATE = ST_ARMED;

  logic unused_sync_level;

  sync_edge_det #(
    .STAGES   (2),
    .W        (1),
    .RISE_BIT (0)
  ) u_sync_det (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .d     (sync_in),
    .level (unused_sync_level),
    .rise  (sync_rise)
  );
`else
  // Without alignment the block runs as soon as it is armed.
  localparam state_t START_STATE = ST_RUN;

  logic unused_sync_in;
  assign unused_sync_in = sync_in;
  assign sync_rise      = 1'b0;
`endif

  // Main FSM with registered outputs.
  //
  // The timer counts up from 0 and a pulse is issued when it reaches the
  // latched period. On every pulse the current period field is latched and
  // the timer restarts, so a period change written mid-period only affects
  // the interval that begins at the next pulse. Arming clears both the timer
  // and the latch so that the first RUN cycle always produces a pulse.
  //
  // In one-shot mode the cycle following the pulse (sync_out still high)
  // returns the block to IDLE, which also stops P=0 from pulsing twice.
  //
  // Stop is checked before anything else: it wins over an arm edge arriving
  // in the same cycle and suppresses a pulse that would otherwise be due.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q    <= ST_IDLE;
      sync_out   <= 1'b0;
      armed      <= 1'b0;
      sync_count <= '0;
      timer_q    <= '0;
      p_lat_q    <= '0;
    end else begin
      sync_out <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
        armed   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arm_edge) begin
              state_q    <= START_STATE;
              armed      <= 1'b1;
              sync_count <= '0;
              timer_q    <= '0;
              p_lat_q    <= '0;
            end
          end

          ST_ARMED: begin
            if (sync_rise) begin
              state_q <= ST_RUN;
            end
          end

          ST_RUN: begin
            if (sync_out && !periodic) begin
              state_q <= ST_IDLE;
              armed   <= 1'b0;
            end else if (timer_q == p_lat_q) begin
              sync_out   <= 1'b1;
              sync_count <= sync_count + CNT_W'(1);
              timer_q    <= '0;
              p_lat_q    <= period_p;
            end else begin
              timer_q <= timer_q + PERIOD_W'(1);
            end
          end

          default: begin
            state_q <= ST_IDLE;
            armed   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : sync_pulse_gen

// File: doc/sync_pulse_gen.md
SYNC_PULSE_GEN -- requirements
Module: sync_pulse_gen

Interface
REQ-001 SHALL have parameter PERIOD_W, default 24, meaning the width of the period field in ctrl_word.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the pulse counter.
REQ-003 SHALL have port user_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port user_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port ctrl_word, input, 32 bits: software control word, user_clk domain, written by the upstream sync_gen software register.
- [31] periodic mode.
- [30] arm, rising-edge triggered.
- [29] stop, level.
- [PERIOD_W-1:0] period minus one, P.
REQ-006 SHALL have port sync_in, input, 1 bit: asynchronous external sync reference.
REQ-007 SHALL have port sync_out, output, 1 bit: sync pulse, one cycle wide.
REQ-008 SHALL have port armed, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port sync_count, output, CNT_W bits: number of pulses emitted since the last arm.

Function
REQ-010 SHALL register ctrl_word once and detect a rising edge on the registered bit [30] (arm_edge).
REQ-011 SHALL use three states: IDLE, ARMED and RUN.
REQ-012 In IDLE, arm_edge SHALL clear sync_count and go to ARMED (or to RUN, see REQ-022).
REQ-013 In ARMED, a synchronised rising edge of sync_in SHALL move the state to RUN.
REQ-014 On the first RUN cycle, the block SHALL assert sync_out, load the timer with P, and latch P.
- P is latched only at a pulse boundary.
- A mid-period change to P takes effect at the next pulse.
REQ-015 In RUN, the timer SHALL decrement each cycle; at 0 it SHALL pulse sync_out and reload with the latched P.
- Pulse period is P+1 cycles.
- P=0 gives sync_out continuously high.
REQ-016 If periodic mode is 0, the block SHALL return to IDLE in the cycle after the first pulse (one-shot).
REQ-017 sync_count SHALL increment on every pulse and wrap from 2^CNT_W-1 to 0 without a flag.
REQ-018 Stop=1 SHALL force IDLE on the next edge from any state.
- It suppresses any pulse in that cycle.
- It has priority over arm_edge in the same cycle.
REQ-019 The following SHALL be ignored:
- arm_edge while in ARMED or RUN;
- a sync_in edge while in IDLE or RUN.
REQ-020 Latency: ctrl_word[30] first sampled 1 at edge n SHALL give sync_out high in the cycle after edge n+2, in a direct-to-RUN build.

Reset
REQ-021 With user_rst_n=0 at a clock edge, the block SHALL take these values:
- state IDLE, sync_out 0, armed 0, sync_count 0;
- timer 0, latched P 0;
- ctrl and sync_in history flops 0.
- An arm bit already high on release does not count as an edge.
- Reset mid-RUN aborts the operation with no further pulse.

Configuration
REQ-022 Macro SYNC_PULSE_GEN_EXT_ALIGN_EN SHALL select whether the block aligns to sync_in.
- Defined: ARMED is used, and sync_in passes through a 2-flop synchroniser and a rise detector. sync_in first sampled 1 at edge n while ARMED gives sync_out high in the cycle after edge n+3.
- Undefined: ARMED is unreachable, arm_edge goes IDLE to RUN directly, and sync_in is unused with no flops.

Structure
REQ-023 Package sync_gen_pkg SHALL hold:
- the state enum;
- the ctrl_word bit-index constants (PERIODIC_BIT=31, ARM_BIT=30, STOP_BIT=29);
- the PERIOD_W and CNT_W defaults.
REQ-024 Sub-module sync_edge_det SHALL provide the synchroniser and rise detector.
- It is parameterised by synchroniser stages: 0 for ctrl_word, 2 for sync_in.
- It is instantiated once for ctrl_word and once for sync_in.

Verification
REQ-025 Periodic, no align: P=9, [31]=1, arm 0->1 -> first pulse at n+3, then every 10 cycles; sync_count=5 after 5 pulses.
REQ-026 One-shot: [31]=0, P=4, arm -> exactly 1 pulse, armed falls the next cycle, sync_count=1; re-arm gives 1 more pulse with sync_count=1.
REQ-027 Align build: arm, wait 50 cycles, sync_in rises -> no pulse before sync_in; pulse at the sync_in edge +3; period P+1 thereafter.
REQ-028 Boundaries: P changes 9->3 mid-period -> current period stays 10, then 4; P=0 -> sync_out constant 1; sync_count preset near 2^32-1 wraps to 0.
REQ-029 Priority and reset: stop and arm rise in the same cycle -> stays IDLE; stop in RUN -> no pulse; user_rst_n low mid-RUN -> all outputs 0; arm held 1 through reset -> no start.
